regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard in front of the 8 x 8-bit register file. It shares the register file's single write port and condition-bit (CB) write port between the ALU write-back stage and the memory-load write-back stage. It tracks registers reserved by in-flight loads and raises a decode stall on read-after-write and write-after-write hazards.

## Interface
Parameters:
- DATA_W, 8, register data width
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W
- STARVE_LIMIT, 2, consecutive refused cycles for an eligible ALU request before ALU gets priority

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- alu_valid_i  in  1  ALU write-back request
- alu_ready_o  out  1  ALU request accepted this cycle
- alu_rf_en_i  in  1  request writes a register
- alu_addr_i  in  ADDR_W  destination register
- alu_data_i  in  DATA_W  result
- alu_cb_en_i  in  1  request writes the CB
- alu_cb_i  in  1  new CB value
- mem_valid_i  in  1  load write-back request
- mem_ready_o  out  1  load request accepted
- mem_addr_i  in  ADDR_W  load destination
- mem_data_i  in  DATA_W  load data
- rsv_i  in  1  decode issues a load; reserve rsv_addr_i
- rsv_addr_i  in  ADDR_W  register to reserve
- rs_addr_i, rt_addr_i  in  ADDR_W each  decode source registers for hazard check
- stall_o  out  1  decode must hold
- busy_o  out  NUM_REGS  scoreboard bits
- write_o  out  1  register-file write enable
- write_addr_o  out  ADDR_W  register-file write address
- write_data_o  out  DATA_W  register-file write data
- write_CB_o  out  1  CB write enable
- cb_data_o  out  1  CB write value

## Operation
- Handshake: a transfer occurs when valid && ready at a rising edge. Requesters hold valid and payload stable until accepted. Ready is combinational from valid, state and busy; it never depends on its own ready.
- ALU eligibility: alu_valid_i && !(alu_rf_en_i && busy[alu_addr_i]). This blocks WAW against an outstanding load. A CB-only request is always eligible.
- Priority FSM, 2 states:
  - MEM_FIRST (reset state): mem wins if mem_valid_i; otherwise an eligible ALU request wins. Each cycle an eligible ALU request is refused, starve_cnt increments. When starve_cnt reaches STARVE_LIMIT, go to ALU_FIRST and clear the count.
  - ALU_FIRST: an eligible ALU request wins over mem. On ALU transfer, return to MEM_FIRST. If ALU becomes ineligible or drops valid, also return to MEM_FIRST.
- At most one register write per cycle. The CB write accompanies only ALU transfers.
- ALU transfer with alu_rf_en_i=0 and alu_cb_en_i=0 is accepted as a no-op.
- Scoreboard:
  - rsv_i sets busy[rsv_addr_i].
  - A mem write to a register clears busy[write_addr_o] on the edge where write_o is high, i.e. the edge the register file captures the data.
  - Simultaneous set and clear on the same address: set wins.
  - A mem write to a non-busy register is performed normally.
- stall_o = busy[rs_addr_i] | busy[rt_addr_i] | (rsv_i && busy[rsv_addr_i]), combinational.
- Widths: all address compares are ADDR_W bits; no arithmetic on data.

## Timing
- Write outputs are registered. A transfer at edge k drives write_o / write_CB_o high for exactly cycle k+1. The register file captures at edge k+1.
- Back-to-back transfers give one write per cycle, full throughput.
- After a load is accepted at edge k, busy clears at edge k+1. stall_o for that register drops in cycle k+2, when the register file holds the new value.
- Reset (asynchronous, any time): write_o=0, write_CB_o=0, write_addr_o=0, write_data_o=0, cb_data_o=0, busy_o=0, state=MEM_FIRST, starve_cnt=0. A write pending in the output register is dropped.
- During reset, alu_ready_o=0, mem_ready_o=0 and stall_o=0.

## Structure
- Shared package regfile_pkg: DATA_W, ADDR_W, NUM_REGS constants; the priority-state enum (MEM_FIRST, ALU_FIRST); the write-back request struct (rf_en, addr, data, cb_en, cb).
- One sub-module, rf_scoreboard:
  - holds the busy vector with its set/clear/priority logic;
  - produces stall_o and the per-address busy lookup used for ALU eligibility.
- The arbiter FSM and output register stay in regfile_wb_arbiter.

## Test plan
- Reset, then ALU transfer (addr 1, data 8'h11, cb_en=1, cb=1) at edge k. Required: write_o, write_CB_o high in cycle k+1 only, with write_addr_o=1, write_data_o=8'h11, cb_data_o=1.
- mem (addr 2, 8'h22) and eligible ALU (addr 3, 8'h33) both valid and held. Required: mem accepted first; ALU refused 2 cycles; ALU then accepted; FSM back in MEM_FIRST.
- Continuous mem_valid_i with ALU pending. Required: ALU accepted no later than the 3rd cycle of its request; one write per cycle; no lost or duplicated data.
- rsv_i with addr 4; ALU request to addr 4; rs_addr_i=4. Required: stall_o=1 and alu_ready_o=0 until the mem write to 4 (8'h44) is captured. stall_o=0 in the following cycle; the ALU write to 4 comes after 8'h44.
- Same-cycle rsv_i addr 5 and a captured mem write to addr 5. Required: busy_o[5] remains 1.
- Assert rst_i mid-cycle with write_o pending and busy_o=8'h30. Required: all outputs 0 immediately, with no write on the following edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
package regfile_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    // Which requester wins a contested write-back cycle.
    typedef enum logic {
        MEM_FIRST = 1'b0,
        ALU_FIRST = 1'b1
    } prio_state_e;

    // One write-back: register write and/or condition-bit write.
    typedef struct packed {
        logic              rf_en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              cb_en;
        logic              cb;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard: loads reserve their destination at issue and
// release it when the load data is written into the register file.
module rf_scoreboard #(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_REGS = 1 << ADDR_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                set_i,
    input  logic [ADDR_W-1:0]   set_addr_i,
    input  logic                clr_i,
    input  logic [ADDR_W-1:0]   clr_addr_i,
    input  logic [ADDR_W-1:0]   rs_addr_i,
    input  logic [ADDR_W-1:0]   rt_addr_i,
    input  logic [ADDR_W-1:0]   lookup_addr_i,
    output logic                lookup_busy_o,
    output logic                stall_o,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Next busy vector: clear first, then set, so a same-address set wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_addr_i] = 1'b0;
        if (set_i) busy_d[set_addr_i] = 1'b1;
    end

    // Busy vector register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    // Hazard lookups against the currently registered busy bits.
    always_comb begin
        lookup_busy_o = busy_q[lookup_addr_i];
        stall_o       = busy_q[rs_addr_i] | busy_q[rt_addr_i]
                      | (set_i & busy_q[set_addr_i]);
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port and CB write port
// between ALU and load write-back, with starvation protection for the ALU.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W       = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W       = regfile_pkg::ADDR_W,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     alu_valid_i,
    output logic                     alu_ready_o,
    input  logic                     alu_rf_en_i,
    input  logic [ADDR_W-1:0]        alu_addr_i,
    input  logic [DATA_W-1:0]        alu_data_i,
    input  logic                     alu_cb_en_i,
    input  logic                     alu_cb_i,
    input  logic                     mem_valid_i,
    output logic                     mem_ready_o,
    input  logic [ADDR_W-1:0]        mem_addr_i,
    input  logic [DATA_W-1:0]        mem_data_i,
    input  logic                     rsv_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    input  logic [ADDR_W-1:0]        rs_addr_i,
    input  logic [ADDR_W-1:0]        rt_addr_i,
    output logic                     stall_o,
    output logic [(1<<ADDR_W)-1:0]   busy_o,
    output logic                     write_o,
    output logic [ADDR_W-1:0]        write_addr_o,
    output logic [DATA_W-1:0]        write_data_o,
    output logic                     write_CB_o,
    output logic                     cb_data_o
);

    import regfile_pkg::*;

    localparam int unsigned CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    prio_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    wb_req_t          wb_q, wb_d;
    logic             from_mem_q, from_mem_d;

    logic alu_busy;
    logic alu_elig;
    logic alu_xfer;
    logic mem_xfer;

    // Scoreboard: load write-back releases its register on the capture edge.
    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (1 << ADDR_W)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .set_i         (rsv_i),
        .set_addr_i    (rsv_addr_i),
        .clr_i         (wb_q.rf_en & from_mem_q),
        .clr_addr_i    (wb_q.addr),
        .rs_addr_i     (rs_addr_i),
        .rt_addr_i     (rt_addr_i),
        .lookup_addr_i (alu_addr_i),
        .lookup_busy_o (alu_busy),
        .stall_o       (stall_o),
        .busy_o        (busy_o)
    );

    // Priority selection, ready generation and starvation counting.
    always_comb begin
        alu_elig    = alu_valid_i & ~(alu_rf_en_i & alu_busy);
        alu_ready_o = 1'b0;
        mem_ready_o = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (!rst_i) begin
            unique case (state_q)
                MEM_FIRST: begin
                    mem_ready_o = mem_valid_i;
                    alu_ready_o = alu_elig & ~mem_valid_i;
                    if (alu_elig && mem_valid_i) begin
                        if (cnt_q + CNT_W'(1) >= CNT_W'(STARVE_LIMIT)) begin
                            state_d = ALU_FIRST;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ALU_FIRST: begin
                    alu_ready_o = alu_elig;
                    mem_ready_o = mem_valid_i & ~alu_elig;
                    // An eligible ALU request always transfers here, so both
                    // the granted and the withdrawn case fall back.
                    state_d     = MEM_FIRST;
                    cnt_d       = '0;
                end
                default: begin
                    state_d = MEM_FIRST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign alu_xfer = alu_valid_i & alu_ready_o;
    assign mem_xfer = mem_valid_i & mem_ready_o;

    // Next write-port contents from whichever requester transferred.
    always_comb begin
        wb_d       = wb_q;
        wb_d.rf_en = 1'b0;
        wb_d.cb_en = 1'b0;
        from_mem_d = 1'b0;
        if (mem_xfer) begin
            wb_d.rf_en = 1'b1;
            wb_d.addr  = mem_addr_i;
            wb_d.data  = mem_data_i;
            from_mem_d = 1'b1;
        end else if (alu_xfer) begin
            wb_d.rf_en = alu_rf_en_i;
            wb_d.cb_en = alu_cb_en_i;
            if (alu_rf_en_i) begin
                wb_d.addr = alu_addr_i;
                wb_d.data = alu_data_i;
            end
            if (alu_cb_en_i) wb_d.cb = alu_cb_i;
        end
    end

    // Priority state, starvation counter and registered write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= MEM_FIRST;
            cnt_q      <= '0;
            wb_q       <= '0;
            from_mem_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_q       <= wb_d;
            from_mem_q <= from_mem_d;
        end
    end

    assign write_o      = wb_q.rf_en;
    assign write_addr_o = wb_q.addr;
    assign write_data_o = wb_q.data;
    assign write_CB_o   = wb_q.cb_en;
    assign cb_data_o    = wb_q.cb;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       alu_valid_i = 1'b0;
    logic       alu_ready_o;
    logic       alu_rf_en_i = 1'b0;
    logic [2:0] alu_addr_i = '0;
    logic [7:0] alu_data_i = '0;
    logic       alu_cb_en_i = 1'b0;
    logic       alu_cb_i = 1'b0;
    logic       mem_valid_i = 1'b0;
    logic       mem_ready_o;
    logic [2:0] mem_addr_i = '0;
    logic [7:0] mem_data_i = '0;
    logic       rsv_i = 1'b0;
    logic [2:0] rsv_addr_i = '0;
    logic [2:0] rs_addr_i = '0;
    logic [2:0] rt_addr_i = '0;
    logic       stall_o;
    logic [7:0] busy_o;
    logic       write_o;
    logic [2:0] write_addr_o;
    logic [7:0] write_data_o;
    logic       write_CB_o;
    logic       cb_data_o;

    int vectors = 0;
    int miscompares = 0;

    regfile_wb_arbiter #(
        .DATA_W       (8),
        .ADDR_W       (3),
        .STARVE_LIMIT (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alu_valid_i  (alu_valid_i),
        .alu_ready_o  (alu_ready_o),
        .alu_rf_en_i  (alu_rf_en_i),
        .alu_addr_i   (alu_addr_i),
        .alu_data_i   (alu_data_i),
        .alu_cb_en_i  (alu_cb_en_i),
        .alu_cb_i     (alu_cb_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_addr_i   (mem_addr_i),
        .mem_data_i   (mem_data_i),
        .rsv_i        (rsv_i),
        .rsv_addr_i   (rsv_addr_i),
        .rs_addr_i    (rs_addr_i),
        .rt_addr_i    (rt_addr_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .write_o      (write_o),
        .write_addr_o (write_addr_o),
        .write_data_o (write_data_o),
        .write_CB_o   (write_CB_o),
        .cb_data_o    (cb_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [2:0] a,
                          input logic [7:0] d, input logic cbwe);
        chk({tag, ".write_o"}, 32'(write_o), 32'(we));
        chk({tag, ".write_CB_o"}, 32'(write_CB_o), 32'(cbwe));
        if (we) begin
            chk({tag, ".addr"}, 32'(write_addr_o), 32'(a));
            chk({tag, ".data"}, 32'(write_data_o), 32'(d));
        end
    endtask

    initial begin
        // Reset: readies held low even with requests present.
        alu_valid_i = 1'b1; mem_valid_i = 1'b1;
        #2;
        chk("rst.alu_ready", 32'(alu_ready_o), 32'd0);
        chk("rst.mem_ready", 32'(mem_ready_o), 32'd0);
        chk("rst.stall", 32'(stall_o), 32'd0);
        chk("rst.write", 32'(write_o), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        tick();
        rst_i = 1'b0;

        // Single ALU transfer with CB write.
        alu_valid_i = 1'b1; alu_rf_en_i = 1'b1; alu_addr_i = 3'd1; alu_data_i = 8'h11;
        alu_cb_en_i = 1'b1; alu_cb_i = 1'b1;
        #1;
        chk("t1.alu_ready", 32'(alu_ready_o), 32'd1);
        tick();
        alu_valid_i = 1'b0;
        chk_wr("t1.k1", 1'b1, 3'd1, 8'h11, 1'b1);
        chk("t1.cb_data", 32'(cb_data_o), 32'd1);
        tick();
        chk_wr("t1.k2", 1'b0, 3'd0, 8'h00, 1'b0);

        // Contention: mem wins twice, ALU then forced through.
        alu_cb_en_i = 1'b0; alu_cb_i = 1'b0;
        mem_valid_i = 1'b1; mem_addr_i = 3'd2; mem_data_i = 8'h22;
        alu_valid_i = 1'b1; alu_addr_i = 3'd3; alu_data_i = 8'h33;
        #1;
        chk("t2.c1.mem_ready", 32'(mem_ready_o), 32'd1);
        chk("t2.c1.alu_ready", 32'(alu_ready_o), 32'd0);
        tick();
        mem_addr_i = 3'd6; mem_data_i = 8'h66;
        chk_wr("t2.w22", 1'b1, 3'd2, 8'h22, 1'b0);
        #1;
        chk("t2.c2.mem_ready", 32'(mem_ready_o), 32'd1);
        chk("t2.c2.alu_ready", 32'(alu_ready_o), 32'd0);
        tick();
        mem_addr_i = 3'd7; mem_data_i = 8'h77;
        chk_wr("t2.w66", 1'b1, 3'd6, 8'h66, 1'b0);
        #1;
        chk("t2.c3.alu_ready", 32'(alu_ready_o), 32'd1);
        chk("t2.c3.mem_ready", 32'(mem_ready_o), 32'd0);
        tick();
        alu_valid_i = 1'b0;
        chk_wr("t2.w33", 1'b1, 3'd3, 8'h33, 1'b0);
        #1;
        chk("t2.c4.mem_ready", 32'(mem_ready_o), 32'd1);
        tick();
        mem_valid_i = 1'b0;
        chk_wr("t2.w77", 1'b1, 3'd7, 8'h77, 1'b0);
        // Back in MEM_FIRST: mem preferred over an eligible ALU request.
        mem_valid_i = 1'b1; alu_valid_i = 1'b1;
        #1;
        chk("t2.state.mem_ready", 32'(mem_ready_o), 32'd1);
        chk("t2.state.alu_ready", 32'(alu_ready_o), 32'd0);
        mem_valid_i = 1'b0; alu_valid_i = 1'b0;
        tick();
        chk_wr("t2.idle", 1'b0, 3'd0, 8'h00, 1'b0);

        // RAW/WAW hazard against a reserved register.
        rsv_i = 1'b1; rsv_addr_i = 3'd4; rs_addr_i = 3'd4;
        #1;
        chk("t4.issue.stall", 32'(stall_o), 32'd0);
        tick();
        rsv_i = 1'b0;
        alu_valid_i = 1'b1; alu_addr_i = 3'd4; alu_data_i = 8'hA4;
        #1;
        chk("t4.busy", 32'(busy_o), 32'h10);
        chk("t4.c1.stall", 32'(stall_o), 32'd1);
        chk("t4.c1.alu_ready", 32'(alu_ready_o), 32'd0);
        tick();
        chk("t4.c2.stall", 32'(stall_o), 32'd1);
        chk("t4.c2.alu_ready", 32'(alu_ready_o), 32'd0);
        mem_valid_i = 1'b1; mem_addr_i = 3'd4; mem_data_i = 8'h44;
        #1;
        chk("t4.c3.mem_ready", 32'(mem_ready_o), 32'd1);
        chk("t4.c3.alu_ready", 32'(alu_ready_o), 32'd0);
        tick();
        mem_valid_i = 1'b0;
        chk_wr("t4.w44", 1'b1, 3'd4, 8'h44, 1'b0);
        chk("t4.k1.stall", 32'(stall_o), 32'd1);
        chk("t4.k1.alu_ready", 32'(alu_ready_o), 32'd0);
        tick();
        chk("t4.k2.write", 32'(write_o), 32'd0);
        chk("t4.k2.stall", 32'(stall_o), 32'd0);
        chk("t4.k2.busy", 32'(busy_o), 32'h00);
        chk("t4.k2.alu_ready", 32'(alu_ready_o), 32'd1);
        tick();
        alu_valid_i = 1'b0; rs_addr_i = 3'd0;
        chk_wr("t4.wA4", 1'b1, 3'd4, 8'hA4, 1'b0);
        tick();
        chk_wr("t4.idle", 1'b0, 3'd0, 8'h00, 1'b0);

        // Set and clear of the same register on one edge: set wins.
        rsv_i = 1'b1; rsv_addr_i = 3'd5;
        tick();
        rsv_i = 1'b0;
        mem_valid_i = 1'b1; mem_addr_i = 3'd5; mem_data_i = 8'h55;
        tick();
        mem_valid_i = 1'b0;
        chk_wr("t5.w55", 1'b1, 3'd5, 8'h55, 1'b0);
        rsv_i = 1'b1; rsv_addr_i = 3'd5;
        #1;
        chk("t5.rsv.stall", 32'(stall_o), 32'd1);
        tick();
        rsv_i = 1'b0;
        chk("t5.busy", 32'(busy_o), 32'h20);
        chk("t5.write", 32'(write_o), 32'd0);

        // Asynchronous reset with a write pending and busy 8'h30.
        rsv_i = 1'b1; rsv_addr_i = 3'd4;
        tick();
        rsv_i = 1'b0;
        alu_valid_i = 1'b1; alu_addr_i = 3'd2; alu_data_i = 8'h99;
        alu_cb_en_i = 1'b1; alu_cb_i = 1'b1; rs_addr_i = 3'd4;
        tick();
        alu_valid_i = 1'b0; alu_cb_en_i = 1'b0;
        chk_wr("t6.pending", 1'b1, 3'd2, 8'h99, 1'b1);
        chk("t6.busy", 32'(busy_o), 32'h30);
        chk("t6.stall", 32'(stall_o), 32'd1);
        #2;
        rst_i = 1'b1; mem_valid_i = 1'b1;
        #1;
        chk("t6.rst.write", 32'(write_o), 32'd0);
        chk("t6.rst.write_CB", 32'(write_CB_o), 32'd0);
        chk("t6.rst.addr", 32'(write_addr_o), 32'd0);
        chk("t6.rst.data", 32'(write_data_o), 32'd0);
        chk("t6.rst.cb_data", 32'(cb_data_o), 32'd0);
        chk("t6.rst.busy", 32'(busy_o), 32'd0);
        chk("t6.rst.stall", 32'(stall_o), 32'd0);
        chk("t6.rst.mem_ready", 32'(mem_ready_o), 32'd0);
        tick();
        chk("t6.edge.write", 32'(write_o), 32'd0);
        mem_valid_i = 1'b0;
        rst_i = 1'b0;
        tick();
        chk("t6.after.write", 32'(write_o), 32'd0);
        chk("t6.after.busy", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
